// File: rtl/wr_circ_buf_split_ctrl.sv
// Circular-buffer write controller: splits a write at the wrap point
// and byte-realigns the tail sub-request's data stream.
module wr_circ_buf_split_ctrl #(
  parameter int DATA_W     = 512,
  parameter int BUF_ADDR_W = 12,
  parameter int LEN_W      = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_wr_buf_req_val,
  input  logic [BUF_ADDR_W-1:0] src_wr_buf_req_addr,
  input  logic [LEN_W-1:0]      src_wr_buf_req_size,
  output logic                  wr_buf_src_req_rdy,
  input  logic                  src_wr_buf_req_data_val,
  input  logic [DATA_W-1:0]     src_wr_buf_req_data,
  output logic                  wr_buf_src_req_data_rdy,
  output logic                  wr_buf_src_wr_req_done,
  input  logic                  src_wr_buf_wr_req_done_rdy,
  output logic                  wr_buf_wr_mem_req_val,
  output logic [BUF_ADDR_W-1:0] wr_buf_wr_mem_req_addr,
  output logic [LEN_W-1:0]      wr_buf_wr_mem_req_size,
  input  logic                  wr_mem_wr_buf_req_rdy,
  output logic                  wr_buf_wr_mem_req_data_val,
  output logic [DATA_W-1:0]     wr_buf_wr_mem_req_data,
  input  logic                  wr_mem_wr_buf_req_data_rdy,
  input  logic                  wr_mem_wr_buf_wr_req_done,
  output logic                  wr_buf_wr_mem_wr_req_done_rdy
);

  localparam int B     = DATA_W / 8;
  localparam int OFF_W = $clog2(B) + 1;
  localparam int SH_W  = OFF_W + 3;
  localparam logic [OFF_W-1:0] OFF_EMPTY = OFF_W'(B);
  localparam logic [LEN_W-1:0] B_L = LEN_W'(B);
  localparam logic [LEN_W-1:0] BUF_SZ = LEN_W'(1) << BUF_ADDR_W;

  typedef enum logic [2:0] {
    IDLE, MAKE_REQ, BUF_DATA, SEND_DATA, WAIT_DONE, DONE_SRC
  } state_t;

  state_t                r_state;
  logic                  r_req_rdy;
  logic                  r_split;
  logic                  r_sub1;
  logic [BUF_ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]      r_len;
  logic [LEN_W-1:0]      r_l1;
  logic [LEN_W-1:0]      r_rem;
  // r_off: index of the first unsent byte in r_save; B means empty.
  logic [OFF_W-1:0]      r_off;
  logic [DATA_W-1:0]     r_save;

  logic [LEN_W-1:0]  w_room;
  logic [LEN_W-1:0]  w_l0;
  logic [LEN_W-1:0]  w_need;
  logic [LEN_W-1:0]  w_have;
  logic [OFF_W-1:0]  w_free;
  logic [OFF_W-1:0]  w_next_off;
  logic [SH_W-1:0]   w_sh_save;
  logic [SH_W-1:0]   w_sh_in;
  logic [DATA_W-1:0] w_beat;
  logic              w_consume;
  logic              w_last;
  logic              w_mid;
  logic              w_send;
  logic              w_beat_fire;

  assign w_room = BUF_SZ - LEN_W'(src_wr_buf_req_addr);
  assign w_l0   = (src_wr_buf_req_size < w_room) ?
                  src_wr_buf_req_size : w_room;

  // A beat needs a fresh source beat only if r_save lacks its bytes.
  assign w_need     = (r_rem > B_L) ? B_L : r_rem;
  assign w_last     = (r_rem <= B_L);
  assign w_have     = B_L - LEN_W'(r_off);
  assign w_consume  = (w_have < w_need);
  assign w_next_off = OFF_W'(LEN_W'(r_off) + w_need -
                      (w_consume ? B_L : '0));
  assign w_free     = OFF_EMPTY - r_off;
  assign w_sh_save  = {r_off, 3'b000};
  assign w_sh_in    = {w_free, 3'b000};
  assign w_beat     = (r_save << w_sh_save) |
                      (w_consume ? (src_wr_buf_req_data >> w_sh_in) : '0);
  assign w_mid      = r_split & ~r_sub1;
  assign w_send     = (r_state == SEND_DATA);

  assign wr_buf_src_req_rdy = r_req_rdy;
  assign wr_buf_wr_mem_req_val = (r_state == MAKE_REQ);
  assign wr_buf_wr_mem_req_addr =
    (r_state == MAKE_REQ) ? r_addr : '0;
  assign wr_buf_wr_mem_req_size =
    (r_state == MAKE_REQ) ? r_len : '0;
  assign wr_buf_wr_mem_req_data_val =
    w_send & (~w_consume | src_wr_buf_req_data_val);
  assign wr_buf_wr_mem_req_data = w_send ? w_beat : '0;
  assign wr_buf_src_req_data_rdy = (r_state == BUF_DATA) |
    (w_send & w_consume & wr_mem_wr_buf_req_data_rdy);
  assign wr_buf_src_wr_req_done = (r_state == DONE_SRC) |
    ((r_state == WAIT_DONE) & ~w_mid & wr_mem_wr_buf_wr_req_done);
  assign wr_buf_wr_mem_wr_req_done_rdy = (r_state == WAIT_DONE) &
    (w_mid | src_wr_buf_wr_req_done_rdy);
  assign w_beat_fire =
    wr_buf_wr_mem_req_data_val & wr_mem_wr_buf_req_data_rdy;

  // Control FSM plus split and realignment bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_req_rdy <= 1'b0;
      r_split   <= 1'b0;
      r_sub1    <= 1'b0;
      r_addr    <= '0;
      r_len     <= '0;
      r_l1      <= '0;
      r_rem     <= '0;
      r_off     <= OFF_EMPTY;
      r_save    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (r_req_rdy && src_wr_buf_req_val) begin
            r_req_rdy <= 1'b0;
            r_addr    <= src_wr_buf_req_addr;
            r_len     <= w_l0;
            r_rem     <= w_l0;
            r_l1      <= src_wr_buf_req_size - w_l0;
            r_split   <= (src_wr_buf_req_size != w_l0);
            r_sub1    <= 1'b0;
            r_off     <= OFF_EMPTY;
            r_save    <= '0;
            r_state   <= (src_wr_buf_req_size == '0) ?
                         DONE_SRC : MAKE_REQ;
          end else begin
            r_req_rdy <= 1'b1;
          end
        end
        MAKE_REQ: begin
          if (wr_mem_wr_buf_req_rdy)
            r_state <= (r_off == OFF_EMPTY) ? BUF_DATA : SEND_DATA;
        end
        BUF_DATA: begin
          if (src_wr_buf_req_data_val) begin
            r_save  <= src_wr_buf_req_data;
            r_off   <= '0;
            r_state <= SEND_DATA;
          end
        end
        SEND_DATA: begin
          if (w_beat_fire) begin
            if (w_consume) r_save <= src_wr_buf_req_data;
            r_off <= w_next_off;
            r_rem <= r_rem - w_need;
            if (w_last) r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (wr_mem_wr_buf_wr_req_done) begin
            if (w_mid) begin
              r_sub1  <= 1'b1;
              r_addr  <= '0;
              r_len   <= r_l1;
              r_rem   <= r_l1;
              r_state <= MAKE_REQ;
            end else if (src_wr_buf_wr_req_done_rdy) begin
              r_state   <= IDLE;
              r_req_rdy <= 1'b1;
            end
          end
        end
        DONE_SRC: begin
          if (src_wr_buf_wr_req_done_rdy) begin
            r_state   <= IDLE;
            r_req_rdy <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_circ_buf_split_ctrl.sv
// Scoreboard bench for wr_circ_buf_split_ctrl: byte-stream reference
// model, randomized handshakes, async reset mid-transfer.
module tb_wr_circ_buf_split_ctrl;
  localparam int DW = 64;
  localparam int AW = 8;
  localparam int LW = 9;
  localparam int B = DW / 8;
  localparam int BUFSZ = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  logic req_val, req_rdy;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_size;
  logic src_val, src_rdy;
  logic [DW-1:0] src_data;
  logic src_done, src_done_rdy;
  logic mreq_val, mreq_rdy;
  logic [AW-1:0] mreq_addr;
  logic [LW-1:0] mreq_size;
  logic mdat_val, mdat_rdy;
  logic [DW-1:0] mdat;
  logic mdone, mdone_rdy;

  always #5 clk = ~clk;

  wr_circ_buf_split_ctrl #(
    .DATA_W(DW), .BUF_ADDR_W(AW), .LEN_W(LW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_wr_buf_req_val(req_val),
    .src_wr_buf_req_addr(req_addr),
    .src_wr_buf_req_size(req_size),
    .wr_buf_src_req_rdy(req_rdy),
    .src_wr_buf_req_data_val(src_val),
    .src_wr_buf_req_data(src_data),
    .wr_buf_src_req_data_rdy(src_rdy),
    .wr_buf_src_wr_req_done(src_done),
    .src_wr_buf_wr_req_done_rdy(src_done_rdy),
    .wr_buf_wr_mem_req_val(mreq_val),
    .wr_buf_wr_mem_req_addr(mreq_addr),
    .wr_buf_wr_mem_req_size(mreq_size),
    .wr_mem_wr_buf_req_rdy(mreq_rdy),
    .wr_buf_wr_mem_req_data_val(mdat_val),
    .wr_buf_wr_mem_req_data(mdat),
    .wr_mem_wr_buf_req_data_rdy(mdat_rdy),
    .wr_mem_wr_buf_wr_req_done(mdone),
    .wr_buf_wr_mem_wr_req_done_rdy(mdone_rdy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;
  int src_taken = 0;
  int n_req = 0;
  int mem_out = 0;
  int hold_left = 0;
  bit pend_done = 0;
  bit bp = 0;
  bit hold_arm = 0;

  logic [AW-1:0] exp_req_addr[$];
  logic [LW-1:0] exp_req_size[$];
  logic [DW-1:0] exp_dat[$];
  logic [DW-1:0] exp_msk[$];
  logic [DW-1:0] src_q[$];
  logic [7:0] ref_bytes[$];

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Scoreboard monitor: sampled on the falling edge.
  logic [DW-1:0] mon_d, mon_m;
  always @(negedge clk) begin
    if (rst) begin
      mem_out = 0;
      pend_done = 0;
    end else begin
      if (pend_done) check("done_stable", src_done, 1);
      pend_done = src_done & ~src_done_rdy;
      if (mreq_val && mreq_rdy) begin
        check("req_order", mem_out, 0);
        check("req_pending", exp_req_addr.size() != 0, 1);
        if (exp_req_addr.size() != 0) begin
          check("req_addr", mreq_addr, exp_req_addr.pop_front());
          check("req_size", mreq_size, exp_req_size.pop_front());
        end
        mem_out++;
        n_req++;
      end
      if (mdat_val && mdat_rdy) begin
        check("dat_pending", exp_dat.size() != 0, 1);
        if (exp_dat.size() != 0) begin
          mon_d = exp_dat.pop_front();
          mon_m = exp_msk.pop_front();
          check("mem_data", mdat & mon_m, mon_d & mon_m);
        end
      end
      if (mdone && mdone_rdy) mem_out--;
      if (src_done && src_done_rdy) done_seen++;
      if (src_val && src_rdy) src_taken++;
    end
  end

  // Source data driver.
  bit s_f;
  always begin
    @(negedge clk);
    s_f = src_val & src_rdy;
    @(posedge clk);
    #1;
    if (rst) src_val = 1'b0;
    else begin
      if (s_f) begin
        void'(src_q.pop_front());
        src_val = 1'b0;
      end
      if (!src_val && src_q.size() > 0 &&
          (!bp || $urandom_range(1, 0) == 1)) begin
        src_val = 1'b1;
        src_data = src_q[0];
      end
    end
  end

  // Memory-side responder.
  bit m_rq, m_dq, m_dn, m_busy;
  int m_left;
  logic [LW-1:0] m_sz;
  always begin
    @(negedge clk);
    m_rq = mreq_val & mreq_rdy;
    m_sz = mreq_size;
    m_dq = mdat_val & mdat_rdy;
    m_dn = mdone & mdone_rdy;
    @(posedge clk);
    #1;
    if (rst) begin
      mreq_rdy = 0; mdat_rdy = 0; mdone = 0;
      m_busy = 0; m_left = 0;
    end else begin
      if (m_rq) begin
        m_busy = 1;
        m_left = (int'(m_sz) + B - 1) / B;
      end
      if (m_dq && m_left > 0) m_left--;
      if (m_dn) begin
        mdone = 0;
        m_busy = 0;
      end else if (m_busy && m_left == 0 && !mdone) begin
        mdone = bp ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      mreq_rdy = bp ? 1'($urandom_range(1, 0)) : 1'b1;
      mdat_rdy = bp ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  // Source done-ready driver, optionally holding off for 10 cycles.
  always begin
    @(posedge clk);
    #2;
    if (rst) begin
      src_done_rdy = 0;
      hold_left = 0;
    end else begin
      if (src_done && hold_arm && hold_left == 0) begin
        hold_left = 10;
        hold_arm = 0;
      end
      if (hold_left > 0) begin
        src_done_rdy = 0;
        hold_left--;
      end else begin
        src_done_rdy = bp ? 1'($urandom_range(1, 0)) : 1'b1;
      end
    end
  end

  task automatic push_sub(input int a, input int lo, input int len);
    logic [DW-1:0] d, m;
    exp_req_addr.push_back(AW'(a));
    exp_req_size.push_back(LW'(len));
    for (int k = 0; k < (len + B - 1) / B; k++) begin
      d = '0;
      m = '0;
      for (int j = 0; j < B; j++) begin
        if (k * B + j < len) begin
          d[DW-1-8*j -: 8] = ref_bytes[lo + k * B + j];
          m[DW-1-8*j -: 8] = 8'hFF;
        end
      end
      exp_dat.push_back(d);
      exp_msk.push_back(m);
    end
  endtask

  int d0, t0, nb_exp;

  task automatic prep_req(input int a, input int sz);
    logic [DW-1:0] w;
    int l0, l1;
    bit got;
    ref_bytes.delete();
    for (int i = 0; i < sz; i++) ref_bytes.push_back(8'($urandom));
    nb_exp = (sz + B - 1) / B;
    for (int k = 0; k < nb_exp; k++) begin
      for (int j = 0; j < B; j++)
        w[DW-1-8*j -: 8] = (k * B + j < sz) ?
                           ref_bytes[k * B + j] : 8'($urandom);
      src_q.push_back(w);
    end
    l0 = (sz < BUFSZ - a) ? sz : BUFSZ - a;
    l1 = sz - l0;
    if (sz > 0) push_sub(a, 0, l0);
    if (l1 > 0) push_sub(0, l0, l1);
    d0 = done_seen;
    t0 = src_taken;
    @(posedge clk);
    #1;
    req_val = 1'b1;
    req_addr = AW'(a);
    req_size = LW'(sz);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_rdy) got = 1;
    end
    @(posedge clk);
    #1;
    req_val = 1'b0;
    check("req_accept", got, 1);
    if (sz == 0) check("zero_done_lat", src_done, 1);
  endtask

  task automatic run_req(input int a, input int sz);
    prep_req(a, sz);
    for (int i = 0; i < 4000 && done_seen == d0; i++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    check("src_done_cnt", done_seen - d0, 1);
    check("src_beats", src_taken - t0, nb_exp);
    check("exp_left", exp_dat.size() + exp_req_addr.size(), 0);
    check("mem_quiet", mem_out, 0);
  endtask

  int ra, rs, r0;

  initial begin
    rst = 1'b1;
    req_val = 0; req_addr = '0; req_size = '0;
    src_val = 0; src_data = '0; src_done_rdy = 0;
    mreq_rdy = 0; mdat_rdy = 0; mdone = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {req_rdy, src_rdy, src_done, mreq_val,
                       mreq_addr, mreq_size, mdat_val, mdone_rdy}, 0);
    check("rst_data", mdat, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_rdy", req_rdy, 1);

    run_req(8'h10, 20);
    run_req(8'hF8, 16);
    run_req(8'hFD, 12);
    run_req(8'h40, 0);
    run_req(8'h00, 256);
    run_req(8'h80, 256);
    run_req(8'hF3, 20);
    run_req(8'hFD, 5);

    bp = 1;
    hold_arm = 1;
    run_req(8'hF8, 16);
    hold_arm = 1;
    run_req(8'hFD, 12);

    for (int i = 0; i < 40; i++) begin
      bp = 1'($urandom_range(1, 0));
      hold_arm = ($urandom_range(3, 0) == 0);
      ra = $urandom_range(BUFSZ - 1, 0);
      rs = (i % 8 == 0) ? 0 : $urandom_range(BUFSZ, 1);
      run_req(ra, rs);
    end
    bp = 0;
    hold_arm = 0;

    r0 = n_req;
    prep_req(8'hFD, 12);
    for (int i = 0; i < 500 && n_req < r0 + 2; i++)
      @(posedge clk);
    check("rst_reach", n_req - r0, 2);
    #3 rst = 1'b1;
    #1;
    check("arst_ctrl", {req_rdy, src_rdy, src_done, mreq_val,
                        mreq_addr, mreq_size, mdat_val, mdone_rdy}, 0);
    check("arst_data", mdat, 0);
    repeat (2) @(posedge clk);
    #4;
    src_q.delete();
    exp_req_addr.delete();
    exp_req_size.delete();
    exp_dat.delete();
    exp_msk.delete();
    check("abandon_done", done_seen - d0, 0);
    rst = 1'b0;
    run_req(8'h10, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
